// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: CPU-to-memory request/ack bus, including the read drive enable for the shared data bus
interface mem_bus_responder_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32
);
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_oe;
  logic                  ack;
  logic                  err;
  modport master (output cs, we, oe, addr, wdata, input rdata, rdata_oe, ack, err);
  modport slave  (input cs, we, oe, addr, wdata, output rdata, rdata_oe, ack, err);
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: wait-stated memory responder with request/ack handshake; MEM_BUS_ERR_EN enables address checking
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1,
  parameter int BASE_ADDR   = 'h100
) (
  input logic             clk,
  input logic             rst,
  mem_bus_responder_if.slave bus
);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] w_off, w_word;
  logic [IW-1:0]         w_idx, r_idx;
  logic                  w_bad, r_bad, r_we, r_ack, r_err, w_accept, w_fire;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  assign w_off  = bus.addr - BASE;
  assign w_word = w_off >> 1;
`ifdef MEM_BUS_ERR_EN
  assign w_idx = w_word[IW-1:0];
  assign w_bad = bus.addr[0] | (bus.addr < BASE) | (w_word >= ADDR_WIDTH'(DEPTH_WORDS));
`else
  assign w_idx = IW'(w_word % ADDR_WIDTH'(DEPTH_WORDS));
  assign w_bad = 1'b0;
`endif
  assign w_accept     = bus.cs & (r_state != S_WAIT);
  assign w_fire       = (r_state == S_WAIT) & (r_cnt == '0);
  assign bus.rdata_oe = bus.cs & bus.oe & ~bus.we;
  assign bus.rdata    = r_rdata;
  assign bus.ack      = r_ack;
  assign bus.err      = r_err;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  // IDLE and ACK both accept a request when cs is high; WAIT leaves once the wait count is spent
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_WAIT) ? ((r_cnt == '0) ? S_ACK : S_WAIT) : (bus.cs ? S_WAIT : S_IDLE);
  end
  // request latch, wait counter and completion outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_fire;
      r_err <= w_fire & r_bad;
      if (w_accept) begin
        r_we    <= bus.we;
        r_bad   <= w_bad;
        r_idx   <= w_idx;
        r_wdata <= bus.wdata;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
      if (w_fire & ~r_we) r_rdata <= r_bad ? '0 : r_mem[r_idx];
    end
  // word store, not reset; bad writes are dropped
  always_ff @(posedge clk)
    if (w_fire & r_we & ~r_bad) r_mem[r_idx] <= r_wdata;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed stimulus checked against a cycle-level behavioural model
module tb_mem_bus_responder;
  localparam int AW = 28, DW = 32, DEPTH = 256, WS = 1;
  localparam logic [27:0] BASE = 28'h100;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mem_bus_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b(), b0();
  mem_bus_responder #(.WAIT_STATES(WS)) u_dut (.clk(clk), .rst(rst), .bus(b));
  mem_bus_responder #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  int n_tot = 0, n_pass = 0, cyc = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  logic [31:0] mm [int];
  logic m_ack = 0, m_err = 0, m_rk = 1;
  logic [31:0] m_rdata = 0;
  bit p_on = 0;
  int p_done = 0, last_done = -100;
  logic [27:0] p_a;
  logic p_we;
  logic [31:0] p_wd;
  function automatic bit is_bad(input logic [27:0] a);
`ifdef MEM_BUS_ERR_EN
    return a[0] || a < BASE || ((a - BASE) >> 1) >= 28'(DEPTH);
`else
    return 0;
`endif
  endfunction
  function automatic int idx_of(input logic [27:0] a);
    logic [27:0] off;
    off = (a - BASE) >> 1;
`ifdef MEM_BUS_ERR_EN
    return int'(off);
`else
    return int'(off % 28'(DEPTH));
`endif
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ack = 0; m_err = 0; m_rdata = 0; m_rk = 1; p_on = 0; last_done = -100;
    end else begin
      m_ack = 0; m_err = 0;
      if (p_on && cyc == p_done) begin
        m_ack = 1; m_err = is_bad(p_a); p_on = 0; last_done = cyc;
        if (p_we) begin
          if (!is_bad(p_a)) mm[idx_of(p_a)] = p_wd;
        end else if (is_bad(p_a)) begin
          m_rdata = 0; m_rk = 1;
        end else if (mm.exists(idx_of(p_a))) begin
          m_rdata = mm[idx_of(p_a)]; m_rk = 1;
        end else m_rk = 0;
      end
      if (!p_on && b.cs && cyc > last_done) begin
        p_on = 1; p_a = b.addr; p_we = b.we; p_wd = b.wdata; p_done = cyc + 1 + WS;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    chk("model_ack", 32'(b.ack), 32'(m_ack));
    chk("model_err", 32'(b.err), 32'(m_err));
    if (m_rk) chk("model_rdata", b.rdata, m_rdata);
    chk("model_rdata_oe", 32'(b.rdata_oe), 32'(b.cs & b.oe & ~b.we));
  end
  task automatic req(input logic [27:0] a, input logic w, input logic o, input logic [31:0] d,
                     output int lat, output logic er, output logic [31:0] rd);
    @(negedge clk);
    b.cs = 1; b.we = w; b.oe = o; b.addr = a; b.wdata = d;
    #1 chk("req_rdata_oe", 32'(b.rdata_oe), 32'(o & ~w));
    @(posedge clk);
    @(negedge clk);
    b.cs = 0; b.addr = ~a; b.wdata = ~d; b.we = ~w;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (b.ack) begin lat = i; break; end
    end
    er = b.err; rd = b.rdata;
  endtask
  int lat;
  logic er;
  logic [31:0] rd, r1, r2;
  logic [6:0] mask;
  initial begin
    b.cs = 0; b.we = 0; b.oe = 0; b.addr = 0; b.wdata = 0;
    b0.cs = 0; b0.we = 0; b0.oe = 0; b0.addr = 0; b0.wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(b.ack), 0);
    chk("rst_err", 32'(b.err), 0);
    chk("rst_rdata", b.rdata, 0);
    @(negedge clk) rst = 0;
    req(28'h100, 1, 0, 32'h1000011E, lat, er, rd);
    chk("wr100_lat", 32'(lat), 2);
    chk("wr100_err", 32'(er), 0);
    req(28'h100, 0, 1, 0, lat, er, rd);
    chk("rd100_lat", 32'(lat), 2);
    chk("rd100_data", rd, 32'h1000011E);
    req(28'h102, 1, 0, 32'h00000120, lat, er, rd);
    req(28'h104, 1, 0, 32'h1800011C, lat, er, rd);
    @(negedge clk);
    b.cs = 1; b.we = 0; b.oe = 1; b.addr = 28'h102;
    mask = 0; r1 = 0; r2 = 0;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      #1;
      mask[e] = b.ack;
      if (e == 2) r1 = b.rdata;
      if (e == 5) r2 = b.rdata;
      @(negedge clk);
      if (e == 0) b.addr = 28'h104;
      if (e == 3) b.cs = 0;
    end
    chk("b2b_ack_edges", 32'(mask), 32'b0100100);
    chk("b2b_rd102", r1, 32'h00000120);
    chk("b2b_rd104", r2, 32'h1800011C);
`ifdef MEM_BUS_ERR_EN
    req(28'h103, 1, 0, 32'hDEAD, lat, er, rd);
    chk("wr103_err", 32'(er), 1);
    req(28'h102, 0, 1, 0, lat, er, rd);
    chk("rd102_err", 32'(er), 0);
    chk("rd102_data", rd, 32'h00000120);
    req(28'h300, 0, 1, 0, lat, er, rd);
    chk("rd300_err", 32'(er), 1);
    chk("rd300_data", rd, 0);
`else
    req(28'h300, 1, 0, 32'h55, lat, er, rd);
    chk("wr300_err", 32'(er), 0);
    req(28'h100, 0, 1, 0, lat, er, rd);
    chk("rd100_wrap", rd, 32'h55);
`endif
    req(28'h11A, 1, 0, 32'hA5A5A5A5, lat, er, rd);
    @(negedge clk);
    b.cs = 1; b.we = 1; b.oe = 0; b.addr = 28'h11A; b.wdata = 32'h78000009;
    @(posedge clk);
    @(negedge clk);
    b.cs = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rstmid_ack", 32'(b.ack), 0);
      chk("rstmid_err", 32'(b.err), 0);
      chk("rstmid_rdata", b.rdata, 0);
      chk("rstmid_rdata_oe", 32'(b.rdata_oe), 0);
    end
    @(negedge clk) rst = 0;
    req(28'h11A, 0, 1, 0, lat, er, rd);
    chk("rd11A_old", rd, 32'hA5A5A5A5);
    req(28'h120, 1, 1, 32'h12, lat, er, rd);
    chk("wr120_lat", 32'(lat), 2);
    req(28'h120, 0, 1, 0, lat, er, rd);
    chk("rd120_data", rd, 32'h12);
    @(negedge clk);
    b0.cs = 1; b0.we = 1; b0.oe = 0; b0.addr = 28'h130; b0.wdata = 32'hCAFE;
    @(posedge clk);
    #1 chk("ws0_wr_ack_early", 32'(b0.ack), 0);
    @(negedge clk) b0.cs = 0;
    @(posedge clk);
    #1 chk("ws0_wr_ack", 32'(b0.ack), 1);
    @(negedge clk);
    b0.cs = 1; b0.we = 0; b0.oe = 1; b0.addr = 28'h130;
    @(posedge clk);
    #1 chk("ws0_rd_ack_early", 32'(b0.ack), 0);
    @(negedge clk) b0.cs = 0;
    @(posedge clk);
    #1;
    chk("ws0_rd_ack", 32'(b0.ack), 1);
    chk("ws0_rd_data", b0.rdata, 32'hCAFE);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU's MAR/data/cs/we/oe memory interface, the target end of what the CPU sequencer initiates.
- Adds a cycle-accurate request/ack handshake, a programmable wait-state count and address checking, so the CPU can be built as a real FSM instead of a fixed-latency bench loop.
- Sits between the CPU core and the word store. The top level builds the shared tristate data bus from wdata/rdata/rdata_oe.

Parameters:
- ADDR_WIDTH, 28, width of addr (MAR).
- DATA_WIDTH, 32, word width.
- DEPTH_WORDS, 256, number of stored words.
- WAIT_STATES, 1, extra cycles inserted before an access completes (0..15).
- BASE_ADDR, 'h100, address of word 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  request strobe. Level-sensitive; held high means back-to-back requests.
- we  in  1  write request.
- oe  in  1  read output enable.
- addr  in  ADDR_WIDTH  request address. Halfword-stepped: instructions sit at even addresses and PC advances by 2.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  registered read data.
- rdata_oe  out  1  bus drive enable: cs & oe & ~we (combinational).
- ack  out  1  one-cycle completion pulse.
- err  out  1  bus error, valid with ack.

Behaviour:
- Reset (async, rst=1): state=IDLE, ack=0, err=0, rdata=0, wait counter=0, latched request cleared. Memory contents are NOT reset.
- Word index = (addr - BASE_ADDR) >> 1.
- Bad address:
  - addr[0]=1 (misaligned), or
  - addr < BASE_ADDR, or
  - index >= DEPTH_WORDS.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - cs=1 at edge: latch addr, we, wdata, bad flag; cnt<=WAIT_STATES; go to WAIT.
  - cs=0: stay in IDLE.
- WAIT:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: perform the access, set ack<=1, err<=bad, go to ACK.
  - Write (latched we=1) and not bad: mem[index]<=wdata.
  - Read and not bad: rdata<=mem[index].
  - Read and bad: rdata<=0.
  - Write: rdata unchanged.
- ACK:
  - ack<=0, err<=0.
  - cs=1: latch the new request and go to WAIT (pipelined accept).
  - cs=0: go to IDLE.
- Latency: request sampled at edge N; access and ack rise at edge N+1+WAIT_STATES; ack high exactly one cycle.
- Back-to-back period with cs held high: WAIT_STATES+2 cycles.
- rdata holds its value until the next read completion.
- Inputs are sampled only at the accept edge. Changes to addr/we/wdata during WAIT are ignored.
- we=1 and oe=1 together: treated as a write; rdata_oe=0.
- Reset mid-operation: pending access aborted, no memory write, no ack.
- Arithmetic: index subtraction done at ADDR_WIDTH bits; unsigned comparisons only.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- Defined: address checking as above; err asserted with ack; bad writes suppressed; bad reads return 0.
- Undefined: err tied to 0; no checking. Index = ((addr - BASE_ADDR) >> 1) mod DEPTH_WORDS, so out-of-range addresses wrap and misaligned addresses alias the lower even address.

Test Plan:
- Reset, WAIT_STATES=1; write 'h1000011E at 'h100 (request at edge 0) -> ack high from edge 2 to edge 3, err=0. Read 'h100 -> rdata='h1000011E with ack, rdata_oe=1 while cs&oe.
- cs held high, reads at 'h102 then 'h104 (preloaded 'h00000120, 'h1800011C) -> acks at edges 2 and 5, each with the correct rdata, no missed or duplicated requests.
- With MEM_BUS_ERR_EN: write 'hDEAD at 'h103 -> ack with err=1. Read-back of 'h102 returns its prior value; read of 'h300 (DEPTH_WORDS=256) -> err=1, rdata=0.
- Without MEM_BUS_ERR_EN: write 'h55 to 'h300 -> err=0; read 'h100 returns 'h55 (wrap).
- Write 'h78000009 to 'h11A, assert rst during WAIT -> no ack, all outputs 0. Later read of 'h11A returns the old value.
- we=1, oe=1, write 'h12 to 'h120 -> rdata_oe=0, write completes. Read 'h120 = 'h12. WAIT_STATES=0 -> ack at edge N+1.
